// File: rtl/multichannel_delay_pkg.sv
// Shared types and helpers for the multi-channel delay line.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
// Contents: sequencer state enum, saturation helper sat_w(sum, w).
package multichannel_delay_pkg;

    // Sequencer states: CLEAR wipes the RAM after reset, IDLE waits for an
    // accepted strobe, RD/RWAIT/WR process one channel, DONE publishes.
    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RD,
        RWAIT,
        WR,
        DONE
    } state_t;

    // Widest sample the saturation helper handles; callers size-cast in/out.
    localparam int SAT_MAX_W = 32;

    // Clamp a signed sum to the w-bit two's complement range
    // [-2^(w-1), 2^(w-1)-1]. The caller keeps the low w bits of the result.
    function automatic logic signed [SAT_MAX_W-1:0] sat_w(
        input logic signed [SAT_MAX_W:0] sum,
        input int                        w
    );
        logic signed [SAT_MAX_W:0] one;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        one = {{SAT_MAX_W{1'b0}}, 1'b1};
        hi  = (one <<< (w - 1)) - one;
        lo  = -hi - one;
        if (sum > hi) begin
            sat_w = hi[SAT_MAX_W-1:0];
        end else if (sum < lo) begin
            sat_w = lo[SAT_MAX_W-1:0];
        end else begin
            sat_w = sum[SAT_MAX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/multichannel_delay_if.sv
// Sample-side bundle of the delay line: frame in, delayed frame out, status.
// Latency: n/a (wires only).
// Backpressure: none; a strobe that arrives while a frame is in flight is dropped.
// Signals: strobe/sample_in/delay_len/fb driven by master; sample_out,
// out_valid, busy, overrun driven by the delay line (slave).
interface multichannel_delay_if #(
    parameter int W        = 16,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 10,
    parameter int FB_W     = 8
);
    logic                       strobe;
    logic [CHANNELS*W-1:0]      sample_in;
    logic [CHANNELS*ADDR_W-1:0] delay_len;
    logic [FB_W-1:0]            fb;
    logic [CHANNELS*W-1:0]      sample_out;
    logic                       out_valid;
    logic                       busy;
    logic                       overrun;

    modport master (
        output strobe, sample_in, delay_len, fb,
        input  sample_out, out_valid, busy, overrun
    );

    modport slave (
        input  strobe, sample_in, delay_len, fb,
        output sample_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/delay_bram.sv
// Simple dual-port sample store shared by all delay voices (infers block RAM).
// Latency: 1 cycle registered read; read data holds until the next read.
// Backpressure: none; one write and one read per cycle.
// Ports: clk; i_we/i_waddr/i_wdat write port; i_re/i_raddr read port; o_rdat.
module delay_bram #(
    parameter int W     = 16,
    parameter int WORDS = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdat,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdat
);
    // No reset on the array or the read register so the tools map this onto
    // a plain block RAM; the sequencer clears the contents after reset.
    logic [W-1:0] r_mem [WORDS];
    logic [W-1:0] r_rdat;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
        if (i_re) begin
            r_rdat <= r_mem[i_raddr];
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/multichannel_delay.sv
// Multi-channel wet-only delay with feedback and decimation, one shared RAM.
// Latency: strobe sampled in cycle t -> out_valid/sample_out in t+3*CHANNELS+2.
// Backpressure: none; strobes while processing are dropped and flag overrun.
// Ports: clk, rst (sync, active-high); bus = slave side of multichannel_delay_if.
module multichannel_delay
    import multichannel_delay_pkg::*;
#(
    parameter int W        = 16,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 1024,
    parameter int DECIMATE = 0,
    parameter int FB_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    multichannel_delay_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RAM_AW = CH_W + ADDR_W;
    localparam int WORDS  = CHANNELS * DEPTH;
    localparam int P_W    = W + FB_W + 1;
    localparam logic [RAM_AW-1:0] CLR_LAST = RAM_AW'(WORDS - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [RAM_AW-1:0]          r_clr_cnt;
    logic [CH_W-1:0]            r_ch;
    logic [ADDR_W-1:0]          r_wptr;
    logic [CHANNELS*W-1:0]      r_sample_in;
    logic [CHANNELS*ADDR_W-1:0] r_delay_len;
    logic [FB_W-1:0]            r_fb;
    logic [CHANNELS*W-1:0]      r_hold;
    logic [CHANNELS*W-1:0]      r_sample_out;
    logic                       r_out_valid;
    logic                       r_overrun;

    logic                       w_skip_zero;
    logic                       w_accept;
    logic                       w_dropped;
    logic                       w_last_ch;
    logic                       w_we;
    logic                       w_re;
    logic [RAM_AW-1:0]          w_waddr;
    logic [RAM_AW-1:0]          w_raddr;
    logic [W-1:0]               w_wdat;
    logic [ADDR_W-1:0]          w_len;
    logic [ADDR_W-1:0]          w_leff;
    logic [ADDR_W-1:0]          w_rd_ptr;
    logic signed [W-1:0]        w_rd_dat;
    logic signed [W-1:0]        w_in;
    logic signed [P_W-1:0]      w_d_ext;
    logic signed [P_W-1:0]      w_fb_ext;
    logic signed [P_W-1:0]      w_prod;
    logic signed [W:0]          w_sum;
    logic [W-1:0]               w_sat;

    // ------------------------------------------------------------------
    // Decimation: only every 2^DECIMATE-th strobe seen in IDLE starts a frame.
    // ------------------------------------------------------------------
    generate
        if (DECIMATE > 0) begin : g_skip
            logic [DECIMATE-1:0] r_skip;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_skip <= '0;
                end else if (r_state == IDLE && bus.strobe) begin
                    r_skip <= r_skip + DECIMATE'(1);
                end
            end
            assign w_skip_zero = (r_skip == '0);
        end else begin : g_no_skip
            assign w_skip_zero = 1'b1;
        end
    endgenerate

    assign w_accept  = (r_state == IDLE) && bus.strobe && w_skip_zero;
    assign w_dropped = (r_state == RD) || (r_state == RWAIT) ||
                       (r_state == WR) || (r_state == DONE);
    assign w_last_ch = (r_ch == CH_W'(CHANNELS - 1));

    // ------------------------------------------------------------------
    // Read address: a zero delay is treated as one frame, so the read slot
    // always trails the write slot and the two ports never collide.
    // ------------------------------------------------------------------
    assign w_len    = r_delay_len[r_ch*ADDR_W +: ADDR_W];
    assign w_leff   = (w_len == '0) ? ADDR_W'(1) : w_len;
    assign w_rd_ptr = r_wptr - w_leff;
    assign w_raddr  = {r_ch, w_rd_ptr};

    // ------------------------------------------------------------------
    // Feedback datapath: in + floor(d * fb / 2^FB_W), saturated to W bits.
    // fb is an unsigned fraction, so it is zero-extended before the signed
    // multiply; the shifted product always fits in W bits.
    // ------------------------------------------------------------------
    assign w_in     = r_sample_in[r_ch*W +: W];
    assign w_d_ext  = P_W'(w_rd_dat);
    assign w_fb_ext = P_W'(r_fb);
    assign w_prod   = w_d_ext * w_fb_ext;
    assign w_sum    = (W+1)'(w_in) + (W+1)'(w_prod >>> FB_W);
    assign w_sat    = W'(sat_w((SAT_MAX_W+1)'(w_sum), W));

    // ------------------------------------------------------------------
    // Sequencer: state register and next-state / RAM control.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_waddr     = {r_ch, r_wptr};
        w_wdat      = w_sat;
        case (r_state)
            CLEAR: begin
                // The clear counter walks the flat address space, which
                // covers every {channel, slot} word exactly once.
                w_we    = 1'b1;
                w_waddr = r_clr_cnt;
                w_wdat  = '0;
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RD;
                end
            end
            RD: begin
                w_re        = 1'b1;
                w_state_nxt = RWAIT;
            end
            RWAIT: begin
                w_state_nxt = WR;
            end
            WR: begin
                w_we        = 1'b1;
                w_state_nxt = w_last_ch ? DONE : RD;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control/status registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt    <= '0;
            r_ch         <= '0;
            r_wptr       <= '0;
            r_sample_out <= '0;
            r_out_valid  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + RAM_AW'(1);
            end
            if (w_accept) begin
                r_ch <= '0;
            end else if (r_state == WR) begin
                r_ch <= r_ch + CH_W'(1);
            end
            if (r_state == DONE) begin
                r_sample_out <= r_hold;
                r_out_valid  <= 1'b1;
                r_wptr       <= r_wptr + ADDR_W'(1);
            end
            if (bus.strobe && w_dropped) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Frame latches and per-channel holding registers carry no reset; they
    // are always loaded before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sample_in <= bus.sample_in;
            r_delay_len <= bus.delay_len;
            r_fb        <= bus.fb;
        end
        if (r_state == WR) begin
            r_hold[r_ch*W +: W] <= w_rd_dat;
        end
    end

    delay_bram #(
        .W     (W),
        .WORDS (WORDS),
        .AW    (RAM_AW)
    ) u_bram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdat  (w_wdat),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdat  (w_rd_dat)
    );

    assign bus.sample_out = r_sample_out;
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = (r_state != IDLE);
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_multichannel_delay.sv
// Directed scoreboard bench for the multi-channel delay line.
// Latency: checks out_valid 14 cycles after each accepted strobe (4 channels).
// Backpressure: exercises dropped strobes (overrun) and decimated strobes.
module tb_multichannel_delay;

    logic clk;
    logic rst;

    multichannel_delay_if #(.W(16), .CHANNELS(4), .ADDR_W(4), .FB_W(8)) if0 ();
    multichannel_delay_if #(.W(16), .CHANNELS(4), .ADDR_W(4), .FB_W(8)) if2 ();

    multichannel_delay #(
        .W(16), .CHANNELS(4), .DEPTH(16), .DECIMATE(0), .FB_W(8)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    multichannel_delay #(
        .W(16), .CHANNELS(4), .DEPTH(16), .DECIMATE(2), .FB_W(8)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vecs;
    int          errs;
    int          n_frame;
    int          hist [4][256];
    logic [63:0] exp_q [$];
    logic [63:0] ins [40];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vecs++;
        assert (obs === want) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reset, then hold strobe high through the clear phase and measure it.
    task automatic do_reset();
        int nb;
        bit ov_ok;
        bit vld_ok;
        @(posedge clk);
        #1 rst = 1'b1;
        if0.strobe = 1'b0;
        if2.strobe = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst sample_out", if0.sample_out, 64'h0);
        check("rst out_valid", {63'h0, if0.out_valid}, 64'h0);
        check("rst overrun", {63'h0, if0.overrun}, 64'h0);
        check("rst busy", {63'h0, if0.busy}, 64'h1);
        rst = 1'b0;
        if0.strobe = 1'b1;
        nb = 0;
        ov_ok = 1'b1;
        vld_ok = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (if0.out_valid !== 1'b0) vld_ok = 1'b0;
            if (if0.overrun !== 1'b0) ov_ok = 1'b0;
            if (if0.busy === 1'b1) nb++;
            else break;
        end
        if0.strobe = 1'b0;
        check("clear busy cycles", 64'(nb), 64'd64);
        check("clear no out_valid", {63'h0, vld_ok}, 64'h1);
        check("clear no overrun", {63'h0, ov_ok}, 64'h1);
        n_frame = 0;
        exp_q.delete();
    endtask

    // Model one accepted frame, queue its expected output, pulse strobe.
    task automatic issue(input logic [63:0] smp, input logic [15:0] len, input logic [7:0] fbv);
        logic [63:0] e;
        int l, o, x, f;
        e = '0;
        f = fbv;
        for (int c = 0; c < 4; c++) begin
            l = len[c*4 +: 4];
            if (l == 0) l = 1;
            o = (n_frame >= l) ? hist[c][n_frame - l] : 0;
            e[c*16 +: 16] = o[15:0];
            x = $signed(smp[c*16 +: 16]);
            hist[c][n_frame] = sat16(x + ((o * f) >>> 8));
        end
        n_frame++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if0.sample_in = smp;
        if0.delay_len = len;
        if0.fb = fbv;
        if0.strobe = 1'b1;
        @(posedge clk);
        #1 if0.strobe = 1'b0;
    endtask

    // Wait (bounded) for out_valid, check latency/busy, pop and compare.
    task automatic wait_out(input int already);
        bit seen;
        bit busy_ok;
        int lat;
        logic [63:0] e;
        seen = 1'b0;
        busy_ok = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (if0.out_valid === 1'b1) begin
                seen = 1'b1;
                lat = already + k;
                if (if0.busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (if0.busy !== 1'b1) busy_ok = 1'b0;
        end
        check("out_valid seen", {63'h0, seen}, 64'h1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        if (seen) begin
            check("latency", 64'(lat), 64'd14);
            check("busy window", {63'h0, busy_ok}, 64'h1);
            check($sformatf("frame %0d out", n_frame - 1), if0.sample_out, e);
        end
    endtask

    task automatic frame(input logic [63:0] smp, input logic [15:0] len, input logic [7:0] fbv);
        issue(smp, len, fbv);
        wait_out(0);
    endtask

    initial begin
        logic [7:0] mask;
        vecs = 0;
        errs = 0;
        n_frame = 0;
        rst = 1'b1;
        if0.strobe = 1'b0;
        if0.sample_in = '0;
        if0.delay_len = '0;
        if0.fb = '0;
        if2.strobe = 1'b0;
        if2.sample_in = '0;
        if2.delay_len = 16'h1111;
        if2.fb = '0;

        // Clear, then first frame reads cleared RAM.
        do_reset();
        frame(64'h1234_1234_1234_1234, 16'h1111, 8'd0);
        check("post-clear zero", if0.sample_out, 64'h0);

        // Pure delay: ch0 L=3, ch1 L=5, ch2 L=1, ch3 L=2.
        do_reset();
        for (int f = 0; f < 8; f++) begin
            frame((f == 0) ? 64'h0000_0000_4000_4000 : 64'h0, 16'h2153, 8'd0);
            if (f == 3) check("delay ch0 f3", {48'h0, if0.sample_out[15:0]}, 64'h4000);
            if (f == 5) check("delay ch1 f5", {48'h0, if0.sample_out[31:16]}, 64'h4000);
        end

        // Feedback: fb=0.5, L=2 on ch0.
        do_reset();
        for (int f = 0; f < 8; f++) begin
            frame((f == 0) ? 64'h0000_0000_0000_4000 : 64'h0, 16'h1112, 8'd128);
            if (f == 4) check("fb ch0 f4", {48'h0, if0.sample_out[15:0]}, 64'h2000);
            if (f == 6) check("fb ch0 f6", {48'h0, if0.sample_out[15:0]}, 64'h1000);
        end

        // Saturation, positive then negative.
        do_reset();
        for (int f = 0; f < 6; f++) frame(64'h7000_7000_7000_7000, 16'h1111, 8'd255);
        check("sat pos", {48'h0, if0.sample_out[15:0]}, 64'h7FFF);
        do_reset();
        for (int f = 0; f < 6; f++) frame(64'h9000_9000_9000_9000, 16'h1111, 8'd255);
        check("sat neg", {48'h0, if0.sample_out[15:0]}, 64'h8000);

        // Clamp (ch0 L=0) and pointer wrap (ch1 L=15) over 40 frames.
        do_reset();
        for (int f = 0; f < 40; f++) begin
            ins[f] = {$urandom, $urandom};
            frame(ins[f], 16'h71F0, 8'd0);
        end
        check("wrap ch1 f39", {48'h0, if0.sample_out[31:16]}, {48'h0, ins[24][31:16]});
        check("clamp ch0 f39", {48'h0, if0.sample_out[15:0]}, {48'h0, ins[38][15:0]});

        // Overrun: strobe 3 cycles after an accepted one is dropped and sticks.
        do_reset();
        issue(64'h0000_0000_0000_0111, 16'h1111, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1 if0.strobe = 1'b1;
        @(posedge clk);
        #1 if0.strobe = 1'b0;
        wait_out(3);
        check("overrun set", {63'h0, if0.overrun}, 64'h1);
        frame(64'h0000_0000_0000_0222, 16'h1111, 8'd0);
        check("overrun sticky", {63'h0, if0.overrun}, 64'h1);
        do_reset();

        // Decimation by 4 on the second instance.
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if2.sample_in = 64'(i + 1) * 64'h0001_0001_0001_0001;
            if2.strobe = 1'b1;
            @(posedge clk);
            #1 if2.strobe = 1'b0;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                if (if2.out_valid === 1'b1) mask[i] = 1'b1;
            end
        end
        check("decim accept mask", {56'h0, mask}, 64'h11);
        check("decim hold", if2.sample_out, 64'h0001_0001_0001_0001);
        check("decim no overrun", {63'h0, if2.overrun}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/multichannel_delay.md
# multichannel_delay

Parametrised multi-channel delay line with per-channel delay length, feedback and sample-rate decimation. All CHANNELS voices share one inferred block RAM, processed one channel at a time by a sequencer. The block sits between the codec sample interface and the output mixer. It outputs the wet signal only; the dry path is mixed elsewhere.

## Interface
- W, 16: sample width, signed two's complement
- CHANNELS, 4: number of independent delay voices
- DEPTH, 1024: samples per channel, power of two; ADDR_W = log2(DEPTH)
- DECIMATE, 0: process one frame per 2^DECIMATE strobes
- FB_W, 8: feedback gain width, unsigned fraction fb/2^FB_W

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- strobe  in  1  one-cycle pulse: new frame present on sample_in
- sample_in  in  CHANNELS*W  channel c at [c*W +: W]
- delay_len  in  CHANNELS*ADDR_W  per-channel delay in processed frames
- fb  in  FB_W  feedback gain, shared by all channels
- sample_out  out  CHANNELS*W  delayed samples, registered
- out_valid  out  1  one-cycle pulse when sample_out updates
- busy  out  1  high while clearing or processing a frame
- overrun  out  1  sticky flag: a strobe was dropped while processing

## Operation
- Reset values: sample_out=0, out_valid=0, overrun=0, wptr=0, skip counter=0, state=CLEAR, clear counter=0.
- Reset asserted mid-operation aborts the frame immediately and restarts CLEAR.
- CLEAR: writes 0 to all CHANNELS*DEPTH RAM words, one word per cycle; busy=1. Strobes arriving in this state are dropped and do not set overrun. Exits to IDLE.
- IDLE: on strobe, the skip counter (DECIMATE bits) is checked.
  - skip != 0: skip is incremented; nothing else happens.
  - skip == 0: skip is incremented (wraps); sample_in, delay_len and fb are latched; channel index is set to 0; state goes to RD.
- With DECIMATE=0, every strobe is accepted.
- Per channel c, three states: RD, RWAIT, WR.
  - RD: read address is {c, wptr - Leff_c}, mod DEPTH.
  - Leff_c = max(delay_len_c, 1); a delay_len of 0 is clamped to 1.
  - RWAIT: RAM has registered read, 1-cycle latency.
  - WR: d = read data, held in the per-channel output holding register. RAM word {c, wptr} is written with sat_W(in_c + ((d * fb) >>> FB_W)).
  - Then c+1 goes to RD, or the last channel goes to DONE.
- Arithmetic:
  - product is signed W+FB_W+1 bits (fb zero-extended);
  - arithmetic shift right (floor);
  - sum is W+1 bits;
  - saturate to [-2^(W-1), 2^(W-1)-1].
- DONE: all holding registers are copied to sample_out; out_valid pulses next cycle; wptr increments (wraps at DEPTH); state goes to IDLE.
- A strobe during RD/RWAIT/WR/DONE is dropped and sets overrun=1. It does not advance skip.
- The read address never equals the write address (Leff ≥ 1), so there is no RAM read/write collision.
- Output for frame n on channel c = the value written at frame n - Leff_c. Frames before the first write read 0 (cleared).

## Timing
- strobe sampled in cycle t; RD(ch0) occurs in cycle t+1.
- WR(ch c) occurs in cycle t+3+3c; DONE in cycle t+3*CHANNELS+1.
- out_valid is high in cycle t+3*CHANNELS+2 (latency 14 for CHANNELS=4); sample_out changes on that same edge.
- busy is high in cycles t+1 through t+3*CHANNELS+1.
- Minimum spacing between accepted strobes: 3*CHANNELS+2 cycles.
- CLEAR lasts CHANNELS*DEPTH cycles after rst deasserts.
- sample_out holds its value between out_valid pulses. With DECIMATE>0 this gives sample-and-hold rate reduction.

## Structure
- Package multichannel_delay_pkg holds:
  - the state enum (CLEAR, IDLE, RD, RWAIT, WR, DONE);
  - the saturation function sat_w(sum, W).
- Sub-module delay_bram:
  - simple dual-port RAM, CHANNELS*DEPTH x W;
  - single clk, registered read, write-enable;
  - infers iCE40 BRAM; no vendor primitive is instantiated.
- Address concatenation, pointer arithmetic, sequencer and feedback datapath live in the top module.

## Test plan
Bench parameters: CHANNELS=4, DEPTH=16, W=16, FB_W=8.
- Clear: pulse rst, then strobe every cycle → busy high for exactly 64 cycles, no out_valid, overrun stays 0, first post-clear frame outputs all 0.
- Pure delay: fb=0, delay_len ch0=3, ch1=5; impulse 0x4000 on both channels at frame 0, then zeros → out0=0x4000 only on frame 3, out1=0x4000 only on frame 5; out_valid exactly 14 cycles after each strobe.
- Feedback: fb=128, L=2, impulse 0x4000 → out0 = 0x4000 at frame 2, 0x2000 at frame 4, 0x1000 at frame 6, 0 at odd frames.
- Saturation: fb=255, L=1, constant 0x7000 → out0 pins at 0x7FFF; constant -0x7000 → pins at 0x8000, with no wrap.
- Clamp and wrap: delay_len=0 behaves as 1; delay_len=15 over 40 frames → out equals input from 15 frames earlier across wptr wrap.
- Decimation and overrun: DECIMATE=2 → one out_valid per 4 strobes; strobe 3 cycles after an accepted strobe → overrun=1, remains set until rst.
